// File: rtl/alu_controlador.sv
// alu_controlador: issue/capture front-end for the combinational 8-bit ALU.
// Ports: req_* valid/ready request in, alu_* to/from the ALU, resp_* valid/ready
//   response out, acc/flags_reg architectural state, op_count completed ops.
// Latency: accept at N -> resp_valid at N+1+SETTLE_CYCLES (illegal ops: N+2).
// Backpressure: one op in flight; resp_* held until resp_ready, no accept meanwhile.
module alu_controlador #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] ACC_RESET     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic        req_use_acc,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_c,
  input  logic [6:0]  alu_flags,
  input  logic [1:0]  alu_cmp,
  input  logic        alu_cout,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_result,
  output logic [6:0]  resp_flags,
  output logic [1:0]  resp_cmp,
  output logic        resp_err,
  output logic [7:0]  acc,
  output logic [6:0]  flags_reg,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       illegal_op;
  logic       div_zero;
  logic       accept;
  logic       capture;
  logic       resp_done;

  // Carry is already flags bit 5; the separate carry pin carries no extra information.
  logic unused_cout;
  assign unused_cout = alu_cout;

  // alu_sel doubles as the latched opcode so the ALU inputs never glitch between ops.
  assign illegal_op = (alu_sel == 4'hE) || (alu_sel == 4'hF);
  assign div_zero   = ((alu_sel == 4'h3) || (alu_sel == 4'h4)) && (alu_b == 8'h00);
  assign accept     = (state == IDLE) && req_valid;
  assign capture    = (state == EXEC) && (state_nxt == RESP);
  assign resp_done  = (state == RESP) && resp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    if (illegal_op || (cnt == 4'd0)) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; handshake outputs are forced low while reset is held
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    if (!rst) begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
    end
  end

  // Datapath: operand latch, settle counter, capture and architectural update
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_sel     <= 4'h0;
      cnt         <= 4'd0;
      resp_result <= 8'h00;
      resp_flags  <= 7'h00;
      resp_cmp    <= 2'b00;
      resp_err    <= 1'b0;
      acc         <= ACC_RESET;
      flags_reg   <= 7'h00;
      op_count    <= 16'h0000;
    end else begin
      if (accept) begin
        alu_a    <= req_use_acc ? acc : req_a;
        alu_b    <= req_b;
        alu_sel  <= req_op;
        cnt      <= 4'(SETTLE_CYCLES - 1);
        resp_err <= 1'b0;
      end

      if ((state == EXEC) && !capture) cnt <= cnt - 4'd1;

      if (capture) begin
        if (illegal_op) begin
          resp_result <= 8'h00;
          resp_flags  <= 7'h00;
          resp_cmp    <= 2'b00;
          resp_err    <= 1'b1;
        end else begin
          resp_result <= alu_c;
          resp_flags  <= alu_flags;
          resp_cmp    <= alu_cmp;
          resp_err    <= div_zero;
          if (!div_zero) begin
            flags_reg <= alu_flags;
            // Compare only updates flags; the accumulator keeps its value.
            if (alu_sel != 4'h5) acc <= alu_c;
          end
        end
      end

      if (resp_done) op_count <= op_count + 16'd1;
    end
  end

endmodule
